pc_bpred: RTL and testbench
===========================

# pc_bpred

Parametrised program counter with dynamic branch prediction for the Tsuki core fetch stage. Holds the fetch PC, decodes the fetched word for conditional branches, and predicts direction. Prediction uses an N-entry fully associative table of 2-bit saturating counters, trained on every resolved branch, with a static backward-taken/forward-not-taken fallback on table miss. Redirects from execute, interrupt and exception logic override prediction; hold stalls fetch.

## Interface
- `ENTRIES`, default 4: table depth; power of two, 2..32.
- `ADDR_W`, default 32: instruction address width.
- `RESET_PC`, default `pc_reset`: value loaded on reset.
- `STATIC_ONLY`, default 0: if 1, the table is not built and BTFN is always used.

- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `jtag_reset_i`, input, 1: synchronous reset, equivalent to `rst_n` (`jtag_rst_enable`).
- `jump_cause_i`, input, `jump_cause_bus`: redirect cause; `jump_cause_no` means no redirect.
- `jump_to_addr_i`, input, `ADDR_W`: redirect target.
- `hold_flag_i`, input, `holdpip_bus`: any value other than `hold_no` stalls the PC.
- `resolve_valid_i`, input, 1: a conditional branch resolved in execute this cycle.
- `resolve_addr_i`, input, `ADDR_W`: address of the resolved branch.
- `resolve_taken_i`, input, 1: actual outcome of the resolved branch.
- `inst_i`, input, 32: instruction word at `pc_o`, valid in the same cycle.
- `pc_o`, output, `ADDR_W`: current fetch PC, registered.
- `predict_to_jump_o`, output, 1: asserted when the fetched branch is predicted taken.

## Operation
- Branch detect: `inst_i[6:0] == inst_b`. Immediate: imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended to `ADDR_W`.
- Table entry: valid, tag (full `ADDR_W` address), 2-bit counter.
  - Counter encoding: 00 strong-not, 01 weak-not, 10 weak-taken, 11 strong-taken.
  - Predict taken when counter[1] = 1.
- Lookup: compare `pc_o` against all valid tags.
  - Hit: use the counter.
  - Miss: BTFN, i.e. taken iff imm_b is negative (inst[31]).
- Next-PC priority (highest first):
  1. Reset gives `RESET_PC`.
  2. `jump_cause_i != jump_cause_no` gives `jump_to_addr_i`.
  3. Hold gives `pc_o` unchanged.
  4. Branch predicted taken gives `pc_o + imm_b`.
  5. Otherwise `pc_o + 4`.
- `predict_to_jump_o` is 1 only in case 4. It is 0 during reset, redirect and hold.
- Training applies when `resolve_valid_i` is 1 and redirect/hold do not block it (training is independent of both).
  - Hit: increment the counter if taken, decrement if not; saturate at 11 and 00.
  - Miss: allocate the entry at the round-robin pointer.
    - Write tag and valid=1.
    - Counter = 10 if taken, 01 if not.
    - Pointer increments modulo `ENTRIES`.
- Tags are unique because allocation happens only on miss. Multi-hit cannot occur; if it does, the lowest index wins.
- Reset:
  - All valid bits cleared.
  - Pointer = 0.
  - `pc_o` = `RESET_PC`.
  - Counters and tags are don't-care.
- `STATIC_ONLY=1`: resolve inputs are ignored and every lookup is a miss.

## Timing
- `pc_o` updates at the rising edge.
- Prediction is combinational from `pc_o`/`inst_i` to next-PC and `predict_to_jump_o` in the same cycle, so redirect penalty is one cycle.
- Table writes take effect at the edge. There is no bypass: a lookup in the same cycle as training on the same address sees the pre-update counter.
- Resolve and lookup in the same cycle are independent; there is one write port and one lookup port.
- Redirect during hold: the redirect wins and the PC is loaded.
- Reset mid-operation takes effect at the next edge and discards in-flight training.
- PC arithmetic wraps modulo 2^`ADDR_W`.

## Structure
- Shared `define.v` holds:
  - counter encodings (`bp_strong_not` .. `bp_strong_taken`);
  - `inst_b`, jump-cause codes, `hold_no`, `pc_reset`.
- Sub-module `bpred_table` holds:
  - the CAM lookup, hit index, counter read;
  - update/allocate logic and the round-robin pointer;
  - parameters `ENTRIES` and `ADDR_W`.
- `pc_bpred` holds the PC register, branch decode, BTFN and next-PC mux.

## Test plan
- Reset, then release, no branches: `pc_o` runs 0x0, 0x4, 0x8; `predict_to_jump_o` stays 0.
- Cold miss at PC 0x100, branch imm -16: predicted taken, next `pc_o` = 0xF0. With imm +16: next `pc_o` = 0x104.
- Train 0x100 not-taken twice (allocated 01, then 00), then fetch the backward branch at 0x100: not taken, next PC 0x104.
- Fill the 4-entry table with 0x10, 0x20, 0x30, 0x40, then resolve 0x50: it replaces entry 0 (0x10). A later fetch of 0x10 falls back to BTFN.
- Same cycle: resolve 0x100 taken (01→10) and fetch 0x100 → prediction uses the old counter 01 (not taken). The following fetch predicts taken.
- Hold with a predicted-taken branch gives `pc_o` unchanged and `predict_to_jump_o` = 0. Redirect to 0x2000 during hold gives `pc_o` = 0x2000 next cycle.

Source files
------------

// File: rtl/pc_bpred_pkg.sv
// Shared fetch-stage definitions: counter encodings, opcode, redirect/hold codes, reset PC.
package pc_bpred_pkg;

  // 2-bit saturating branch direction counter
  typedef enum logic [1:0] {
    bp_strong_not   = 2'b00,
    bp_weak_not     = 2'b01,
    bp_weak_taken   = 2'b10,
    bp_strong_taken = 2'b11
  } bp_ctr_e;

  localparam int unsigned JUMP_CAUSE_W = 2;
  typedef enum logic [JUMP_CAUSE_W-1:0] {
    jump_cause_no  = 2'd0,
    jump_cause_exe = 2'd1,
    jump_cause_int = 2'd2,
    jump_cause_exc = 2'd3
  } jump_cause_e;

  localparam int unsigned HOLDPIP_W = 3;
  typedef enum logic [HOLDPIP_W-1:0] {
    hold_no = 3'd0,
    hold_pc = 3'd1,
    hold_if = 3'd2,
    hold_id = 3'd3
  } holdpip_e;

  localparam logic [6:0]  inst_b   = 7'b1100011;
  localparam logic [31:0] pc_reset = 32'h0000_0000;

  // Saturating counter update toward the resolved outcome
  function automatic bp_ctr_e bp_ctr_step(input bp_ctr_e cur, input logic taken);
    bp_ctr_e nxt;
    nxt = cur;
    if (taken) begin
      if (cur != bp_strong_taken) nxt = bp_ctr_e'(cur + 2'd1);
    end else begin
      if (cur != bp_strong_not) nxt = bp_ctr_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpred_table.sv
// Fully associative table of 2-bit counters with round-robin allocation on miss.
module bpred_table
  import pc_bpred_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [1:0]        ctr_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_addr_i,
  input  logic              upd_taken_i
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ADDR_W-1:0] tag_q [ENTRIES];
  bp_ctr_e           ctr_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic              lk_hit;
  logic [IDX_W-1:0]  lk_idx;
  logic              up_hit;
  logic [IDX_W-1:0]  up_idx;
  logic [IDX_W-1:0]  wr_idx;

  // Lookup CAM: lowest matching index wins
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!lk_hit && valid_q[i] && (tag_q[i] == lookup_addr_i)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  assign hit_o = lk_hit;
  assign ctr_o = lk_hit ? ctr_q[lk_idx] : 2'b00;

  // Update CAM on the resolve port, independent of the lookup port
  always_comb begin
    up_hit = 1'b0;
    up_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!up_hit && valid_q[i] && (tag_q[i] == upd_addr_i)) begin
        up_hit = 1'b1;
        up_idx = IDX_W'(i);
      end
    end
  end

  assign wr_idx = up_hit ? up_idx : ptr_q;

  // Next valid bits and allocation pointer
  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (upd_valid_i && !up_hit) begin
      valid_d[wr_idx] = 1'b1;
      ptr_d = (ENTRIES > 1) ? IDX_W'(ptr_q + 1'b1) : '0;
    end
  end

  // Valid bits and pointer are the only reset state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Tag and counter storage; contents are don't-care until valid is set
  always_ff @(posedge clk) begin
    if (rst_n && upd_valid_i) begin
      if (up_hit) begin
        ctr_q[wr_idx] <= bp_ctr_step(ctr_q[wr_idx], upd_taken_i);
      end else begin
        tag_q[wr_idx] <= upd_addr_i;
        ctr_q[wr_idx] <= upd_taken_i ? bp_weak_taken : bp_weak_not;
      end
    end
  end

endmodule

// File: rtl/pc_bpred.sv
// Fetch PC register with branch decode, dynamic/BTFN prediction and next-PC selection.
module pc_bpred
  import pc_bpred_pkg::*;
#(
  parameter int unsigned       ENTRIES     = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(pc_reset),
  parameter bit                STATIC_ONLY = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    jtag_reset_i,
  input  logic [JUMP_CAUSE_W-1:0] jump_cause_i,
  input  logic [ADDR_W-1:0]       jump_to_addr_i,
  input  logic [HOLDPIP_W-1:0]    hold_flag_i,
  input  logic                    resolve_valid_i,
  input  logic [ADDR_W-1:0]       resolve_addr_i,
  input  logic                    resolve_taken_i,
  input  logic [31:0]             inst_i,
  output logic [ADDR_W-1:0]       pc_o,
  output logic                    predict_to_jump_o
);

  logic              rst_active;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              is_branch;
  logic [ADDR_W-1:0] imm_b;
  logic              tbl_hit;
  logic [1:0]        tbl_ctr;
  logic              pred_taken;
  logic              redirect;
  logic              hold;

  assign rst_active = !rst_n || jtag_reset_i;
  assign redirect   = (jump_cause_i != jump_cause_no);
  assign hold       = (hold_flag_i != hold_no);

  assign is_branch = (inst_i[6:0] == inst_b);
  assign imm_b = {{(ADDR_W-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  generate
    if (STATIC_ONLY) begin : g_static
      logic unused_resolve;
      assign unused_resolve = ^{resolve_valid_i, resolve_addr_i, resolve_taken_i};
      assign tbl_hit = 1'b0;
      assign tbl_ctr = 2'b00;
    end else begin : g_table
      bpred_table #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
      ) u_table (
        .clk           (clk),
        .rst_n         (!rst_active),
        .lookup_addr_i (pc_q),
        .hit_o         (tbl_hit),
        .ctr_o         (tbl_ctr),
        .upd_valid_i   (resolve_valid_i),
        .upd_addr_i    (resolve_addr_i),
        .upd_taken_i   (resolve_taken_i)
      );
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{inst_i[24:12], tbl_ctr[0]};

  // Direction: table counter on hit, backward-taken/forward-not-taken on miss
  always_comb begin
    pred_taken = 1'b0;
    if (is_branch) begin
      pred_taken = tbl_hit ? tbl_ctr[1] : inst_i[31];
    end
  end

  // Next-PC priority: reset, redirect, hold, predicted taken, sequential
  always_comb begin
    pc_d              = pc_q + ADDR_W'(4);
    predict_to_jump_o = 1'b0;
    if (rst_active) begin
      pc_d = RESET_PC;
    end else if (redirect) begin
      pc_d = jump_to_addr_i;
    end else if (hold) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d              = pc_q + imm_b;
      predict_to_jump_o = 1'b1;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: tb/tb_pc_bpred.sv
// Directed bench for pc_bpred with hand-computed expectations.
module tb_pc_bpred;
  import pc_bpred_pkg::*;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BR_BWD = 32'hFE00_08E3; // beq, imm -16
  localparam logic [31:0] BR_FWD = 32'h0000_0863; // beq, imm +16

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jtag_reset_i;
  logic [1:0]  jump_cause_i;
  logic [31:0] jump_to_addr_i;
  logic [2:0]  hold_flag_i;
  logic        resolve_valid_i;
  logic [31:0] resolve_addr_i;
  logic        resolve_taken_i;
  logic [31:0] inst_i;
  logic [31:0] pc_o;
  logic        predict_to_jump_o;

  int checks = 0;
  int errors = 0;

  pc_bpred #(
    .ENTRIES     (4),
    .ADDR_W      (32),
    .RESET_PC    (32'h0),
    .STATIC_ONLY (1'b0)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .jtag_reset_i      (jtag_reset_i),
    .jump_cause_i      (jump_cause_i),
    .jump_to_addr_i    (jump_to_addr_i),
    .hold_flag_i       (hold_flag_i),
    .resolve_valid_i   (resolve_valid_i),
    .resolve_addr_i    (resolve_addr_i),
    .resolve_taken_i   (resolve_taken_i),
    .inst_i            (inst_i),
    .pc_o              (pc_o),
    .predict_to_jump_o (predict_to_jump_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] addr);
    jump_cause_i   = jump_cause_exe;
    jump_to_addr_i = addr;
    step();
    jump_cause_i   = jump_cause_no;
    jump_to_addr_i = '0;
  endtask

  task automatic resolve(input logic [31:0] addr, input logic taken);
    resolve_valid_i = 1'b1;
    resolve_addr_i  = addr;
    resolve_taken_i = taken;
    step();
    resolve_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; jtag_reset_i = 1'b0;
    jump_cause_i = jump_cause_no; jump_to_addr_i = '0;
    hold_flag_i = hold_no;
    resolve_valid_i = 1'b0; resolve_addr_i = '0; resolve_taken_i = 1'b0;
    inst_i = BR_BWD;

    // Reset state, prediction suppressed while in reset
    step(); step();
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_pred", {31'b0, predict_to_jump_o}, 32'h0);
    inst_i = NOP;
    rst_n  = 1'b1;
    chk("rel_pc0", pc_o, 32'h0);
    step();
    chk("rel_pc4", pc_o, 32'h4);
    chk("rel_pred", {31'b0, predict_to_jump_o}, 32'h0);
    step();
    chk("rel_pc8", pc_o, 32'h8);

    // Cold miss: backward taken, forward not taken
    redirect_to(32'h100);
    chk("redir_100", pc_o, 32'h100);
    inst_i = BR_BWD; #1;
    chk("miss_bwd_pred", {31'b0, predict_to_jump_o}, 32'h1);
    step();
    chk("miss_bwd_pc", pc_o, 32'hF0);
    inst_i = NOP;
    redirect_to(32'h100);
    inst_i = BR_FWD; #1;
    chk("miss_fwd_pred", {31'b0, predict_to_jump_o}, 32'h0);
    step();
    chk("miss_fwd_pc", pc_o, 32'h104);
    inst_i = NOP;

    // Train 0x100 not-taken twice: 01 then 00, overrides BTFN
    resolve(32'h100, 1'b0);
    resolve(32'h100, 1'b0);
    redirect_to(32'h100);
    inst_i = BR_BWD; #1;
    chk("trained_nt_pred", {31'b0, predict_to_jump_o}, 32'h0);
    step();
    chk("trained_nt_pc", pc_o, 32'h104);
    inst_i = NOP;

    // Reset clears valid bits: 0x100 is a miss again
    do_reset();
    redirect_to(32'h100);
    inst_i = BR_BWD; #1;
    chk("post_reset_miss", {31'b0, predict_to_jump_o}, 32'h1);
    inst_i = NOP;

    // Fill table, then 0x50 replaces entry 0 (0x10)
    resolve(32'h10, 1'b1);
    resolve(32'h20, 1'b1);
    resolve(32'h30, 1'b1);
    resolve(32'h40, 1'b1);
    resolve(32'h50, 1'b1);
    redirect_to(32'h10);
    inst_i = BR_FWD; #1;
    chk("evicted_btfn", {31'b0, predict_to_jump_o}, 32'h0);
    step();
    chk("evicted_pc", pc_o, 32'h14);
    inst_i = NOP;
    redirect_to(32'h20);
    inst_i = BR_FWD; #1;
    chk("kept_20_pred", {31'b0, predict_to_jump_o}, 32'h1);
    step();
    chk("kept_20_pc", pc_o, 32'h30);
    inst_i = NOP;
    redirect_to(32'h50);
    inst_i = BR_FWD; #1;
    chk("new_50_pred", {31'b0, predict_to_jump_o}, 32'h1);
    inst_i = NOP;

    // Same-cycle train and lookup sees the old counter (01), next fetch sees 10
    resolve(32'h100, 1'b0);
    redirect_to(32'h100);
    inst_i = BR_BWD;
    resolve_valid_i = 1'b1; resolve_addr_i = 32'h100; resolve_taken_i = 1'b1;
    #1;
    chk("bypass_old_pred", {31'b0, predict_to_jump_o}, 32'h0);
    step();
    resolve_valid_i = 1'b0;
    chk("bypass_old_pc", pc_o, 32'h104);
    redirect_to(32'h100);
    #1;
    chk("bypass_new_pred", {31'b0, predict_to_jump_o}, 32'h1);
    step();
    chk("bypass_new_pc", pc_o, 32'hF0);

    // Hold suppresses prediction; redirect wins over hold
    redirect_to(32'h100);
    hold_flag_i = hold_if; #1;
    chk("hold_pred", {31'b0, predict_to_jump_o}, 32'h0);
    step();
    chk("hold_pc", pc_o, 32'h100);
    jump_cause_i = jump_cause_int; jump_to_addr_i = 32'h2000; #1;
    chk("redir_pred", {31'b0, predict_to_jump_o}, 32'h0);
    step();
    jump_cause_i = jump_cause_no;
    hold_flag_i  = hold_no;
    chk("hold_redir_pc", pc_o, 32'h2000);

    // PC wraps modulo 2^32
    inst_i = NOP;
    redirect_to(32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc_o, 32'h0);

    // JTAG reset behaves like rst_n
    step();
    jtag_reset_i = 1'b1;
    step();
    jtag_reset_i = 1'b0;
    chk("jtag_reset_pc", pc_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
